// File: rtl/led_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_pkg
// Purpose  : Mode/direction encodings and helpers shared by the LED sequencer.
// Revision : 1.0
// ============================================================================
package led_seq_pkg;

    localparam int RATE_SEL_W = 2;

    typedef enum logic [1:0] {
        FLASH   = 2'b00,
        SHIFT_L = 2'b01,
        SHIFT_R = 2'b10,
        BOUNCE  = 2'b11
    } mode_e;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    function automatic mode_e next_mode(input mode_e m);
        mode_e r;
        case (m)
            FLASH:   r = SHIFT_L;
            SHIFT_L: r = SHIFT_R;
            SHIFT_R: r = BOUNCE;
            default: r = FLASH;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : led_sequencer_if
// Purpose  : Switch/button inputs and LED/mode outputs of the LED sequencer.
// Revision : 1.0
// ============================================================================
interface led_sequencer_if #(
    parameter int NB_LEDS = 4
);
    logic [2:0]         i_sw;
    logic               i_btn;
    logic [NB_LEDS-1:0] o_led;
    logic [1:0]         o_state;

    modport master (output i_sw, output i_btn, input o_led, input o_state);
    modport slave  (input i_sw, input i_btn, output o_led, output o_state);
endinterface
`default_nettype wire

// File: rtl/led_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Enabled prescaler; one-cycle tick when count reaches limit-1.
// Revision : 1.0
// ============================================================================
module tick_gen #(
    parameter int NB_COUNT = 32
) (
    input  wire logic                clock,
    input  wire logic                i_reset,
    input  wire logic                i_enable,
    input  wire logic                i_clear,
    input  wire logic [NB_COUNT-1:0] i_limit,
    output logic                     o_tick
);
    logic [NB_COUNT-1:0] r_count_q;
    logic [NB_COUNT-1:0] w_count_d;
    logic [NB_COUNT-1:0] w_limit_m1;
    logic                w_tick;

    // >= rather than == so a switch to a shorter period fires at once
    always_comb begin
        w_limit_m1 = i_limit - NB_COUNT'(1);
        w_tick     = i_enable && (r_count_q >= w_limit_m1);
        w_count_d  = r_count_q;
        if (i_clear) begin
            w_count_d = '0;
        end else if (w_tick) begin
            w_count_d = '0;
        end else if (i_enable) begin
            w_count_d = r_count_q + NB_COUNT'(1);
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_sequencer
// Purpose  : Tick-driven LED pattern sequencer with button-stepped modes.
// Revision : 1.0
// ============================================================================
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NB_LEDS  = 4,
    parameter int NB_COUNT = 32,
    parameter int TICK_R0  = 2**23,
    parameter int TICK_R1  = 2**24,
    parameter int TICK_R2  = 2**25,
    parameter int TICK_R3  = 2**26
) (
    input  wire logic      clock,
    input  wire logic      i_reset,
    led_sequencer_if.slave bus
);
    localparam logic [NB_LEDS-1:0] C_LSB_HOT = NB_LEDS'(1);
    localparam logic [NB_LEDS-1:0] C_MSB_HOT = {1'b1, {(NB_LEDS-1){1'b0}}};

    logic [NB_COUNT-1:0] w_limit;
    logic                w_tick;
    logic                w_rise;

    logic                r_btn_q, w_btn_d;
    logic                r_btn_prev_q, w_btn_prev_d;
    mode_e               r_mode_q, w_mode_d;
    logic                r_dir_q, w_dir_d;
    logic [NB_LEDS-1:0]  r_led_q, w_led_d;
    logic [NB_LEDS-1:0]  w_shift;

    always_comb begin
        case (bus.i_sw[2:1])
            2'd0:    w_limit = NB_COUNT'(TICK_R0);
            2'd1:    w_limit = NB_COUNT'(TICK_R1);
            2'd2:    w_limit = NB_COUNT'(TICK_R2);
            default: w_limit = NB_COUNT'(TICK_R3);
        endcase
    end

    // Registered edge: sampled at one edge, acted on at the next
    assign w_btn_d      = bus.i_btn;
    assign w_btn_prev_d = r_btn_q;
    assign w_rise       = r_btn_q & ~r_btn_prev_q;

    tick_gen #(
        .NB_COUNT (NB_COUNT)
    ) u_tick_gen (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (bus.i_sw[0]),
        .i_clear  (w_rise),
        .i_limit  (w_limit),
        .o_tick   (w_tick)
    );

    // A mode change takes priority; a coincident tick is dropped
    always_comb begin
        w_mode_d = r_mode_q;
        w_dir_d  = r_dir_q;
        w_led_d  = r_led_q;
        w_shift  = '0;
        if (w_rise) begin
            w_mode_d = next_mode(r_mode_q);
            w_dir_d  = LEFT;
            case (w_mode_d)
                FLASH:   w_led_d = '0;
                SHIFT_R: w_led_d = C_MSB_HOT;
                default: w_led_d = C_LSB_HOT;
            endcase
        end else if (w_tick) begin
            case (r_mode_q)
                FLASH:   w_led_d = ~r_led_q;
                SHIFT_L: w_led_d = {r_led_q[NB_LEDS-2:0], r_led_q[NB_LEDS-1]};
                SHIFT_R: w_led_d = {r_led_q[0], r_led_q[NB_LEDS-1:1]};
                default: begin
                    if (r_dir_q == LEFT) begin
                        w_shift = r_led_q << 1;
                        if (w_shift[NB_LEDS-1]) w_dir_d = RIGHT;
                    end else begin
                        w_shift = r_led_q >> 1;
                        if (w_shift[0]) w_dir_d = LEFT;
                    end
                    w_led_d = w_shift;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_btn_q      <= 1'b0;
            r_btn_prev_q <= 1'b0;
            r_mode_q     <= FLASH;
            r_dir_q      <= LEFT;
            r_led_q      <= '0;
        end else begin
            r_btn_q      <= w_btn_d;
            r_btn_prev_q <= w_btn_prev_d;
            r_mode_q     <= w_mode_d;
            r_dir_q      <= w_dir_d;
            r_led_q      <= w_led_d;
        end
    end

    assign bus.o_led   = r_led_q;
    assign bus.o_state = r_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_sequencer
// Purpose  : Scoreboard bench: stimulus queues timed LED/mode changes.
// Revision : 1.0
// ============================================================================
module tb_led_sequencer;

    typedef struct {
        int         ev_cyc;
        logic [3:0] led;
        logic [1:0] st;
    } exp_t;

    logic clk;
    logic i_reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    led_sequencer_if #(.NB_LEDS(4)) bus ();

    led_sequencer #(
        .NB_LEDS  (4),
        .NB_COUNT (32),
        .TICK_R0  (4),
        .TICK_R1  (8),
        .TICK_R2  (16),
        .TICK_R3  (32)
    ) dut (
        .clock   (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] led, input logic [1:0] st);
        exp_t e;
        e.ev_cyc = c;
        e.led    = led;
        e.st     = st;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic goto_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic press();
        bus.i_btn = 1'b1;
        @(negedge clk);
        bus.i_btn = 1'b0;
    endtask

    // Monitor: every output change must match the next queued expectation
    initial begin : monitor
        logic [3:0] last_led;
        logic [1:0] last_st;
        exp_t       e;
        last_led = '0;
        last_st  = '0;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].ev_cyc < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missed_change: led=%b state=%b due at cycle %0d not seen by cycle %0d",
                         e.led, e.st, e.ev_cyc, cyc);
            end
            if (bus.o_led !== last_led || bus.o_state !== last_st) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: cycle %0d got led=%b state=%b, expected no change",
                             cyc, bus.o_led, bus.o_state);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.o_led !== e.led || bus.o_state !== e.st || cyc != e.ev_cyc) begin
                        n_fail++;
                        $display("FAIL output_change: got led=%b state=%b at cycle %0d, expected led=%b state=%b at cycle %0d",
                                 bus.o_led, bus.o_state, cyc, e.led, e.st, e.ev_cyc);
                    end
                end
                last_led = bus.o_led;
                last_st  = bus.o_state;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int t;
        logic [3:0] bounce_pat [7];
        bounce_pat = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        n_checks  = 0;
        n_fail    = 0;
        bus.i_sw  = 3'b001;
        bus.i_btn = 1'b0;
        i_reset   = 1'b1;
        #1 i_reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_led", int'(bus.o_led), 0);
        chk("reset_state", int'(bus.o_state), 0);

        // FLASH from reset release: toggles on the 4th and 8th enabled cycles
        t = cyc;
        i_reset = 1'b1;
        push(t + 4, 4'b1111, 2'b00);
        push(t + 8, 4'b0000, 2'b00);
        goto_cyc(t + 9);

        // SHIFT_L
        t = cyc;
        press();
        push(t + 2,  4'b0001, 2'b01);
        push(t + 6,  4'b0010, 2'b01);
        push(t + 10, 4'b0100, 2'b01);
        push(t + 14, 4'b1000, 2'b01);
        push(t + 18, 4'b0001, 2'b01);
        goto_cyc(t + 19);

        // SHIFT_R, then a button edge timed to coincide with the second tick
        t = cyc;
        press();
        push(t + 2, 4'b1000, 2'b10);
        push(t + 6, 4'b0100, 2'b10);
        goto_cyc(t + 8);
        press();
        push(t + 10, 4'b0001, 2'b11);
        for (int k = 0; k < 7; k++) push(t + 14 + 4 * k, bounce_pat[k], 2'b11);
        goto_cyc(t + 39);

        // Asynchronous reset between clock edges
        #2 i_reset = 1'b0;
        #1;
        chk("async_reset_led", int'(bus.o_led), 0);
        chk("async_reset_state", int'(bus.o_state), 0);
        push(cyc + 1, 4'b0000, 2'b00);
        repeat (2) @(negedge clk);

        // Release, disable for 20 cycles, re-enable at rate 3, then rate 0
        t = cyc;
        i_reset = 1'b1;
        push(t + 4, 4'b1111, 2'b00);
        goto_cyc(t + 5);
        bus.i_sw = 3'b000;
        goto_cyc(t + 25);
        bus.i_sw = 3'b111;
        push(t + 56, 4'b0000, 2'b00);
        push(t + 88, 4'b1111, 2'b00);
        goto_cyc(t + 108);
        bus.i_sw = 3'b001;
        push(t + 109, 4'b0000, 2'b00);
        push(t + 113, 4'b1111, 2'b00);
        push(t + 117, 4'b0000, 2'b00);
        goto_cyc(t + 118);

        // Button held for 50 cycles while disabled: exactly one advance
        t = cyc;
        bus.i_sw  = 3'b000;
        bus.i_btn = 1'b1;
        push(t + 2, 4'b0001, 2'b01);
        repeat (50) @(negedge clk);
        bus.i_btn = 1'b0;
        repeat (10) @(negedge clk);

        chk("pending_expectations", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
